// File: rtl/fetch_npc_ctrl.sv
// Instruction-fetch control: next-PC selection with stall hold and buffered redirects,
// plus the IF/ID pipeline register, fetch-address legality check and fetch counter.
module fetch_npc_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_f,
   input  logic [31:0] instr_f,
   input  logic        stall,
   input  logic        flush_d,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] npc,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        fetch_exc_d,
   output logic        redirect_pending,
   output logic [31:0] fetch_count
);

   typedef enum logic {IDLE, PENDING} state_e;

   // Range bounds are held in 33 bits so the upper limit cannot wrap.
   localparam logic [32:0] PC_LO = {1'b0, PC_RESET};
   localparam logic [32:0] PC_HI = PC_LO + (33'(IM_WORDS) << 2);

   state_e      state_q, state_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] instr_q, pc_q, pc8_q, cnt_q;
   logic        valid_q, exc_q;
   logic        ill;

   assign ill = (pc_f[1:0] != 2'b00) || ({1'b0, pc_f} < PC_LO) || ({1'b0, pc_f} >= PC_HI);

   always_comb begin
      npc = pc_f + 32'd4;
      if (reset)                  npc = PC_RESET;
      else if (stall)             npc = pc_f;
      else if (redirect_valid)    npc = redirect_target;
      else if (state_q == PENDING) npc = pend_q;
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (stall && redirect_valid) begin
               state_d = PENDING;
               pend_d  = redirect_target;
            end
         end
         PENDING: begin
            // A newer redirect during the stall supersedes the buffered one.
            if (stall && redirect_valid) pend_d  = redirect_target;
            else if (!stall)             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= PC_RESET;
         pc8_q   <= PC_RESET + 32'd8;
         valid_q <= 1'b0;
         exc_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (flush_d) begin
         instr_q <= '0;
         pc_q    <= pc_f;
         pc8_q   <= pc_f + 32'd8;
         valid_q <= 1'b0;
         exc_q   <= 1'b0;
      end else if (!stall) begin
         instr_q <= ill ? 32'd0 : instr_f;
         pc_q    <= pc_f;
         pc8_q   <= pc_f + 32'd8;
         valid_q <= 1'b1;
         exc_q   <= ill;
         cnt_q   <= cnt_q + 32'd1;
      end
   end

   assign instr_d          = instr_q;
   assign pc_d             = pc_q;
   assign pc8_d            = pc8_q;
   assign valid_d          = valid_q;
   assign fetch_exc_d      = exc_q;
   assign redirect_pending = (state_q == PENDING);
   assign fetch_count      = cnt_q;

endmodule

// File: tb/tb_fetch_npc_ctrl.sv
// Bench for fetch_npc_ctrl: directed vector table, then randomized traffic against a reference model.
module tb_fetch_npc_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall, flush_d, redirect_valid;
   logic [31:0] pc_f, instr_f, redirect_target;
   logic [31:0] npc, instr_d, pc_d, pc8_d, fetch_count;
   logic        valid_d, fetch_exc_d, redirect_pending;

   int total = 0;
   int bad   = 0;

   fetch_npc_ctrl dut (
      .clk(clk), .reset(reset), .pc_f(pc_f), .instr_f(instr_f), .stall(stall),
      .flush_d(flush_d), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .npc(npc), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d),
      .fetch_exc_d(fetch_exc_d), .redirect_pending(redirect_pending), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, st, fl, rv;
      logic [31:0] pc, ins, tgt;
      logic [31:0] e_npc;
      logic        e_valid, e_exc, e_pend;
      logic [31:0] e_instr, e_pcd, e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic f, input logic v,
                        input logic [31:0] p, input logic [31:0] i, input logic [31:0] t);
      reset = r; stall = s; flush_d = f; redirect_valid = v;
      pc_f = p; instr_f = i; redirect_target = t;
   endtask

   task automatic chk_regs(input string tag, input logic ev, input logic ee, input logic ep,
                           input logic [31:0] ei, input logic [31:0] epc, input logic [31:0] ec);
      chk({tag, " valid_d"}, 32'(valid_d), 32'(ev));
      chk({tag, " fetch_exc_d"}, 32'(fetch_exc_d), 32'(ee));
      chk({tag, " redirect_pending"}, 32'(redirect_pending), 32'(ep));
      chk({tag, " instr_d"}, instr_d, ei);
      chk({tag, " pc_d"}, pc_d, epc);
      chk({tag, " pc8_d"}, pc8_d, epc + 32'd8);
      chk({tag, " fetch_count"}, fetch_count, ec);
   endtask

   function automatic void add(input logic r, s, f, v, input logic [31:0] p, i, t, en,
                               input logic ev, ee, ep, input logic [31:0] ei, epc, ec);
      vec_t x;
      x.rst = r; x.st = s; x.fl = f; x.rv = v; x.pc = p; x.ins = i; x.tgt = t; x.e_npc = en;
      x.e_valid = ev; x.e_exc = ee; x.e_pend = ep; x.e_instr = ei; x.e_pcd = epc; x.e_cnt = ec;
      vecs.push_back(x);
   endfunction

   // Reference model state: buffered redirect and IF/ID contents.
   bit          m_pend;
   logic [31:0] m_tgt, m_instr, m_pcd, m_cnt;
   bit          m_valid, m_exc;

   function automatic bit legal(input logic [31:0] p);
      longint a = longint'(p);
      return (a % 4 == 0) && (a >= 64'h3000) && (a < 64'h3000 + 4 * 4096);
   endfunction

   initial begin
      //    rst st fl rv  pc            instr         target        npc          vld exc pnd instr_d       pc_d          count
      add(1, 0, 0, 0, 32'h3000,     32'h0,        32'h0,    32'h3000,     0, 0, 0, 32'h0,        32'h3000,     0);
      add(0, 0, 0, 0, 32'h3000,     32'h3C011234, 32'h0,    32'h3004,     1, 0, 0, 32'h3C011234, 32'h3000,     1);
      add(0, 1, 0, 0, 32'h3004,     32'hAAAAAAAA, 32'h0,    32'h3004,     1, 0, 0, 32'h3C011234, 32'h3000,     1);
      add(0, 1, 0, 0, 32'h3004,     32'hAAAAAAAA, 32'h0,    32'h3004,     1, 0, 0, 32'h3C011234, 32'h3000,     1);
      add(0, 1, 0, 0, 32'h3004,     32'hAAAAAAAA, 32'h0,    32'h3004,     1, 0, 0, 32'h3C011234, 32'h3000,     1);
      add(0, 1, 0, 1, 32'h3004,     32'hAAAAAAAA, 32'h3040, 32'h3004,     1, 0, 1, 32'h3C011234, 32'h3000,     1);
      add(0, 0, 0, 0, 32'h3004,     32'h11111111, 32'h0,    32'h3040,     1, 0, 0, 32'h11111111, 32'h3004,     2);
      add(0, 1, 1, 0, 32'h3010,     32'h22222222, 32'h0,    32'h3010,     0, 0, 0, 32'h0,        32'h3010,     2);
      add(0, 0, 0, 0, 32'h3002,     32'h33333333, 32'h0,    32'h3006,     1, 1, 0, 32'h0,        32'h3002,     3);
      add(0, 0, 0, 0, 32'h7000,     32'h33333333, 32'h0,    32'h7004,     1, 1, 0, 32'h0,        32'h7000,     4);
      add(0, 0, 0, 0, 32'h6FFC,     32'h44444444, 32'h0,    32'h7000,     1, 0, 0, 32'h44444444, 32'h6FFC,     5);
      add(0, 0, 0, 0, 32'hFFFFFFFC, 32'h55555555, 32'h0,    32'h0,        1, 1, 0, 32'h0,        32'hFFFFFFFC, 6);
      // newest redirect wins while held in a stall
      add(0, 1, 0, 1, 32'h3000,     32'h0,        32'h3100, 32'h3000,     1, 1, 1, 32'h0,        32'hFFFFFFFC, 6);
      add(0, 1, 0, 1, 32'h3000,     32'h0,        32'h3200, 32'h3000,     1, 1, 1, 32'h0,        32'hFFFFFFFC, 6);
      add(0, 1, 0, 0, 32'h3000,     32'h0,        32'h0,    32'h3000,     1, 1, 1, 32'h0,        32'hFFFFFFFC, 6);
      add(0, 0, 0, 0, 32'h3000,     32'h66666666, 32'h0,    32'h3200,     1, 0, 0, 32'h66666666, 32'h3000,     7);
      // fresh redirect on release beats the buffered one
      add(0, 1, 0, 1, 32'h3004,     32'h0,        32'h3300, 32'h3004,     1, 0, 1, 32'h66666666, 32'h3000,     7);
      add(0, 0, 0, 1, 32'h3004,     32'h77777777, 32'h3400, 32'h3400,     1, 0, 0, 32'h77777777, 32'h3004,     8);
      // reset while PENDING discards the buffered redirect
      add(0, 1, 0, 1, 32'h3008,     32'h0,        32'h3500, 32'h3008,     1, 0, 1, 32'h77777777, 32'h3004,     8);
      add(1, 1, 0, 1, 32'h3008,     32'h0,        32'h3500, 32'h3000,     0, 0, 0, 32'h0,        32'h3000,     0);
      add(0, 0, 0, 0, 32'h3000,     32'h88888888, 32'h0,    32'h3004,     1, 0, 0, 32'h88888888, 32'h3000,     1);

      drive(1, 0, 0, 0, 32'h3000, 32'h0, 32'h0);
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         drive(vecs[k].rst, vecs[k].st, vecs[k].fl, vecs[k].rv, vecs[k].pc, vecs[k].ins, vecs[k].tgt);
         #1 chk({tag, " npc"}, npc, vecs[k].e_npc);
         @(posedge clk); #1;
         chk_regs(tag, vecs[k].e_valid, vecs[k].e_exc, vecs[k].e_pend,
                  vecs[k].e_instr, vecs[k].e_pcd, vecs[k].e_cnt);
      end

      // Model picks up from the last table entry.
      m_pend = 0; m_tgt = 0; m_valid = 1; m_exc = 0;
      m_instr = 32'h88888888; m_pcd = 32'h3000; m_cnt = 1;

      for (int n = 0; n < 400; n++) begin
         logic        r, s, f, v;
         logic [31:0] p, i, t, exp_npc;
         string       tag;
         tag = $sformatf("rnd%0d", n);
         r = ($urandom_range(0, 39) == 0);
         s = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 5) == 0);
         v = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 4))
            0:       p = $urandom;
            1:       p = 32'h3000 + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(1, 3));
            default: p = 32'h3000 + 32'($urandom_range(0, 4097)) * 4;
         endcase
         i = $urandom;
         t = $urandom & 32'hFFFF_FFFC;
         drive(r, s, f, v, p, i, t);

         // Next PC: reset vector, hold, live redirect, buffered redirect, or sequential.
         if (r)           exp_npc = 32'h3000;
         else if (s)      exp_npc = p;
         else if (v)      exp_npc = t;
         else if (m_pend) exp_npc = m_tgt;
         else             exp_npc = p + 32'd4;
         #1 chk({tag, " npc"}, npc, exp_npc);

         if (r) begin
            m_pend = 0; m_tgt = 0; m_valid = 0; m_exc = 0;
            m_instr = 0; m_pcd = 32'h3000; m_cnt = 0;
         end else begin
            if (s && v) begin m_pend = 1; m_tgt = t; end
            else if (!s) m_pend = 0;
            if (f) begin
               m_instr = 0; m_valid = 0; m_exc = 0; m_pcd = p;
            end else if (!s) begin
               m_valid = 1; m_exc = !legal(p); m_instr = legal(p) ? i : 32'h0;
               m_pcd = p; m_cnt = m_cnt + 1;
            end
         end
         @(posedge clk); #1;
         chk_regs(tag, m_valid, m_exc, m_pend, m_instr, m_pcd, m_cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
